pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 174 +++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, filters the synchronised lock,
// then releases downstream reset domains in index order.
module pll_lock_supervisor #(
  parameter int N_DOM       = 2,
  parameter int PLL_RST_CYC = 16,
  parameter int LOCK_FILT   = 64,
  parameter int REL_GAP     = 8,
  parameter int LOCK_TMO    = 65535,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lock_i,
  input  logic             clr_cnt_i,
  output logic             pll_rst_o,
  output logic [N_DOM-1:0] dom_rst_n_o,
  output logic             ready_o,
  output logic [CNT_W-1:0] loss_cnt_o,
  output logic [CNT_W-1:0] tmo_cnt_o,
  output logic [2:0]       state_o
);

  localparam int M1 = (PLL_RST_CYC > LOCK_TMO) ? PLL_RST_CYC : LOCK_TMO;
  localparam int M2 = (LOCK_FILT > REL_GAP) ? LOCK_FILT : REL_GAP;
  localparam int MX = (M1 > M2) ? M1 : M2;
  localparam int TW = $clog2(MX + 1);

  typedef enum logic [2:0] {
    S_PLL_RST = 3'd0,
    S_WAIT    = 3'd1,
    S_FILT    = 3'd2,
    S_REL     = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  logic [1:0]       r_sync;
  state_t           r_state;
  logic [TW-1:0]    r_tcnt;
  logic [2:0]       r_idx;
  logic             r_pll_rst;
  logic [N_DOM-1:0] r_dom;
  logic             r_ready;
  logic [CNT_W-1:0] r_loss;
  logic [CNT_W-1:0] r_tmo;

  state_t           w_nxt;
  logic [TW-1:0]    w_tcnt_nxt;
  logic [2:0]       w_idx_nxt;
  logic [N_DOM-1:0] w_dom_nxt;
  logic             w_loss_ev;
  logic             w_tmo_ev;
  logic             w_lock_s;

  assign w_lock_s = r_sync[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[0], lock_i};
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_tcnt_nxt = r_tcnt + TW'(1);
    w_idx_nxt  = r_idx;
    w_dom_nxt  = r_dom;
    w_loss_ev  = 1'b0;
    w_tmo_ev   = 1'b0;
    unique case (r_state)
      S_PLL_RST: begin
        w_dom_nxt = '0;
        if (r_tcnt == TW'(PLL_RST_CYC - 1)) begin
          w_nxt      = S_WAIT;
          w_tcnt_nxt = '0;
        end
      end
      S_WAIT: begin
        if (w_lock_s) begin
          w_nxt      = S_FILT;
          w_tcnt_nxt = '0;
        end else if (r_tcnt == TW'(LOCK_TMO - 1)) begin
          w_nxt      = S_PLL_RST;
          w_tcnt_nxt = '0;
          w_tmo_ev   = 1'b1;
        end
      end
      S_FILT: begin
        if (!w_lock_s) begin
          w_nxt      = S_WAIT;
          w_tcnt_nxt = '0;
        end else if (r_tcnt == TW'(LOCK_FILT - 1)) begin
          w_nxt      = S_REL;
          w_tcnt_nxt = '0;
          w_idx_nxt  = '0;
          w_dom_nxt  = N_DOM'(1);
        end
      end
      S_REL: begin
        if (!w_lock_s) begin
          w_nxt      = S_PLL_RST;
          w_tcnt_nxt = '0;
          w_dom_nxt  = '0;
          w_loss_ev  = 1'b1;
        end else if (r_idx == 3'(N_DOM - 1)) begin
          w_nxt      = S_RUN;
          w_tcnt_nxt = '0;
          w_dom_nxt  = {N_DOM{1'b1}};
        end else if (r_tcnt == TW'(REL_GAP - 1)) begin
          // release the next domain; earlier ones stay released
          w_tcnt_nxt = '0;
          w_idx_nxt  = r_idx + 3'd1;
          w_dom_nxt  = r_dom | (N_DOM'(1) << (r_idx + 3'd1));
        end
      end
      S_RUN: begin
        w_tcnt_nxt = '0;
        if (!w_lock_s) begin
          w_nxt     = S_PLL_RST;
          w_dom_nxt = '0;
          w_loss_ev = 1'b1;
        end
      end
      default: begin
        w_nxt      = S_PLL_RST;
        w_tcnt_nxt = '0;
        w_dom_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_PLL_RST;
      r_tcnt    <= '0;
      r_idx     <= '0;
      r_pll_rst <= 1'b1;
      r_dom     <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_idx     <= w_idx_nxt;
      r_pll_rst <= (w_nxt == S_PLL_RST);
      r_dom     <= w_dom_nxt;
      r_ready   <= (w_nxt == S_RUN);
    end
  end

  // clear has priority over a coincident event
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_loss <= '0;
      r_tmo  <= '0;
    end else if (clr_cnt_i) begin
      r_loss <= '0;
      r_tmo  <= '0;
    end else begin
      if (w_loss_ev && (r_loss != {CNT_W{1'b1}}))
        r_loss <= r_loss + CNT_W'(1);
      if (w_tmo_ev && (r_tmo != {CNT_W{1'b1}}))
        r_tmo <= r_tmo + CNT_W'(1);
    end
  end

  assign pll_rst_o   = r_pll_rst;
  assign dom_rst_n_o = r_dom;
  assign ready_o     = r_ready;
  assign loss_cnt_o  = r_loss;
  assign tmo_cnt_o   = r_tmo;
  assign state_o     = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: timed checkpoints queued per scenario,
// popped and compared on the cycle they fall due.
module tb_pll_lock_supervisor;

  localparam logic [2:0] PR = 3'd0;
  localparam logic [2:0] WT = 3'd1;
  localparam logic [2:0] FL = 3'd2;
  localparam logic [2:0] RL = 3'd3;
  localparam logic [2:0] RN = 3'd4;
  localparam int TP = 116;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock_i = 1'b1;
  logic       clr_cnt_i = 1'b0;
  logic       pll_rst_o;
  logic [1:0] dom_rst_n_o;
  logic       ready_o;
  logic [7:0] loss_cnt_o;
  logic [7:0] tmo_cnt_o;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .N_DOM(2), .PLL_RST_CYC(16), .LOCK_FILT(64),
    .REL_GAP(8), .LOCK_TMO(100), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lock_i(lock_i),
    .clr_cnt_i(clr_cnt_i), .pll_rst_o(pll_rst_o),
    .dom_rst_n_o(dom_rst_n_o), .ready_o(ready_o),
    .loss_cnt_o(loss_cnt_o), .tmo_cnt_o(tmo_cnt_o),
    .state_o(state_o)
  );

  typedef struct {
    int         cyc;
    string      nm;
    logic [2:0] st;
    logic [1:0] dom;
    logic [7:0] loss;
    logic [7:0] tmo;
  } exp_t;

  typedef struct {
    int         off;
    string      nm;
    logic [2:0] st;
    logic [1:0] dom;
  } row_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      exp_t e;
      logic ok;
      e = sbq.pop_front();
      n_chk++;
      ok = (e.cyc == cyc) && (state_o == e.st) &&
           (pll_rst_o == (e.st == PR)) &&
           (ready_o == (e.st == RN)) &&
           (dom_rst_n_o == e.dom) &&
           (loss_cnt_o == e.loss) && (tmo_cnt_o == e.tmo);
      if (!ok) begin
        n_fail++;
        $display("FAIL %s @%0d/%0d got st=%0d pr=%b dom=%b rdy=%b loss=%0d tmo=%0d exp st=%0d pr=%b dom=%b rdy=%b loss=%0d tmo=%0d",
          e.nm, cyc, e.cyc, state_o, pll_rst_o, dom_rst_n_o,
          ready_o, loss_cnt_o, tmo_cnt_o, e.st, e.st == PR,
          e.dom, e.st == RN, e.loss, e.tmo);
      end
    end
  end

  task automatic push(input int at, input string nm,
                      input logic [2:0] st, input logic [1:0] dom,
                      input int loss, input int tmo);
    exp_t e;
    e.cyc = at; e.nm = nm; e.st = st; e.dom = dom;
    e.loss = 8'(loss); e.tmo = 8'(tmo);
    sbq.push_back(e);
  endtask

  task automatic to_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  row_t p1[9];

  initial begin
    int b, n, m, q, p, x;
    p1 = '{
      '{1,  "prst_start", PR, 2'b00},
      '{15, "prst_end",   PR, 2'b00},
      '{16, "wait",       WT, 2'b00},
      '{17, "filter",     FL, 2'b00},
      '{80, "filt_end",   FL, 2'b00},
      '{81, "dom0",       RL, 2'b01},
      '{88, "dom0_only",  RL, 2'b01},
      '{89, "dom1",       RL, 2'b11},
      '{90, "run",        RN, 2'b11}
    };

    @(negedge clk);
    push(cyc + 1, "reset", PR, 2'b00, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b = cyc;
    foreach (p1[i]) push(b + p1[i].off, p1[i].nm, p1[i].st, p1[i].dom, 0, 0);
    to_cyc(b + 95);

    n = cyc;
    lock_i = 1'b0;
    push(n + 2, "run_hold", RN, 2'b11, 0, 0);
    push(n + 3, "run_loss", PR, 2'b00, 1, 0);
    @(negedge clk);
    lock_i = 1'b1;
    push(n + 18, "re_prst",  PR, 2'b00, 1, 0);
    push(n + 19, "re_wait",  WT, 2'b00, 1, 0);
    push(n + 20, "re_filt",  FL, 2'b00, 1, 0);
    push(n + 84, "re_dom0",  RL, 2'b01, 1, 0);
    push(n + 92, "re_dom1",  RL, 2'b11, 1, 0);
    push(n + 93, "re_run",   RN, 2'b11, 1, 0);
    to_cyc(n + 100);

    m = cyc;
    rst_n = 1'b0;
    push(m + 1, "rst_in_run", PR, 2'b00, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b = cyc;
    push(b + 16, "wait2", WT, 2'b00, 0, 0);
    push(b + 17, "filt2", FL, 2'b00, 0, 0);
    to_cyc(b + 30);
    lock_i = 1'b0;
    @(negedge clk);
    lock_i = 1'b1;
    push(b + 32,  "filt_hold",    FL, 2'b00, 0, 0);
    push(b + 33,  "filt_drop",    WT, 2'b00, 0, 0);
    push(b + 34,  "filt_again",   FL, 2'b00, 0, 0);
    push(b + 97,  "filt_restart", FL, 2'b00, 0, 0);
    push(b + 98,  "rel2",         RL, 2'b01, 0, 0);
    push(b + 107, "run2",         RN, 2'b11, 0, 0);
    to_cyc(b + 110);

    q = cyc;
    lock_i = 1'b0;
    @(negedge clk);
    lock_i = 1'b1;
    @(negedge clk);
    clr_cnt_i = 1'b1;
    push(q + 3, "clr_vs_loss", PR, 2'b00, 0, 0);
    @(negedge clk);
    clr_cnt_i = 1'b0;
    push(q + 19, "wait3", WT, 2'b00, 0, 0);
    push(q + 20, "filt3", FL, 2'b00, 0, 0);
    push(q + 84, "rel3",  RL, 2'b01, 0, 0);
    to_cyc(q + 85);
    lock_i = 1'b0;
    push(q + 87, "rel_hold",   RL, 2'b01, 0, 0);
    push(q + 88, "rel_loss",   PR, 2'b00, 1, 0);
    push(q + 92, "dom1_never", PR, 2'b00, 1, 0);

    p = q + 88;
    push(p + 16,           "tmo_wait0", WT, 2'b00, 1, 0);
    push(p + TP - 1,       "tmo_pre1",  WT, 2'b00, 1, 0);
    push(p + TP,           "tmo1",      PR, 2'b00, 1, 1);
    push(p + 2 * TP - 1,   "tmo_pre2",  WT, 2'b00, 1, 1);
    push(p + 2 * TP,       "tmo2",      PR, 2'b00, 1, 2);
    push(p + 254 * TP,     "tmo254",    PR, 2'b00, 1, 254);
    push(p + 255 * TP,     "tmo255",    PR, 2'b00, 1, 255);
    push(p + 257 * TP - 1, "tmo_pre",   WT, 2'b00, 1, 255);
    push(p + 257 * TP,     "tmo_sat",   PR, 2'b00, 1, 255);
    to_cyc(p + 257 * TP + 5);

    x = cyc;
    clr_cnt_i = 1'b1;
    push(x + 1, "clr", PR, 2'b00, 0, 0);
    @(negedge clk);
    clr_cnt_i = 1'b0;
    to_cyc(x + 3);

    n_chk++;
    if (pll_rst_o !== 1'b1) begin
      n_fail++;
      $display("FAIL end_prst pr=%b", pll_rst_o);
    end
    n_chk++;
    if (dom_rst_n_o !== 2'b00) begin
      n_fail++;
      $display("FAIL end_dom dom=%b", dom_rst_n_o);
    end
    n_chk++;
    if (ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL end_rdy rdy=%b", ready_o);
    end
    n_chk++;
    if (loss_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL end_loss loss=%0d", loss_cnt_o);
    end
    n_chk++;
    if (tmo_cnt_o !== 8'd0) begin
      n_fail++;
      $display("FAIL end_tmo tmo=%0d", tmo_cnt_o);
    end

    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL %s never checked, due at %0d, now %0d", e.nm, e.cyc, cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
